// File: rtl/j1_boot_ctrl_if.sv
// rtl/j1_boot_ctrl_if.sv - byte stream, program RAM write and response port bundle for j1_boot_ctrl
//
// Signals:
//   rx_data_i  [7:0]  received byte, qualified by rx_valid_i
//   rx_valid_i        one-cycle strobe per received byte
//   ram_addr_o [12:0] program RAM write word address
//   ram_data_o [15:0] program RAM write data
//   ram_we_o          one-cycle program RAM write strobe
//   tx_data_o  [7:0]  response byte
//   tx_valid_o        response valid, held until tx_ready_i
//   tx_ready_i        response accepted
// Modports:
//   slave  - the boot controller (consumes rx, produces RAM writes and response)
//   master - the host/system side
interface j1_boot_ctrl_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [12:0] ram_addr_o;
  logic [15:0] ram_data_o;
  logic        ram_we_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;

  modport slave (
    input  rx_data_i, rx_valid_i, tx_ready_i,
    output ram_addr_o, ram_data_o, ram_we_o, tx_data_o, tx_valid_o
  );

  modport master (
    output rx_data_i, rx_valid_i, tx_ready_i,
    input  ram_addr_o, ram_data_o, ram_we_o, tx_data_o, tx_valid_o
  );
endinterface

// File: rtl/j1_boot_ctrl.sv
// rtl/j1_boot_ctrl.sv - serial program loader and reset sequencer for the J1 core
//
// Receives a frame A5, LEN_H, LEN_L, LEN x {hi, lo} [, CSUM], writes the words
// into program RAM from address 0, answers with one byte ('K' ok, 'E' bad
// length/checksum, 'T' inter-byte timeout) and releases the core after 'K'.
//
// Optional feature macro: J1_BOOT_CHECKSUM_EN (adds the trailing CSUM byte,
// XOR of LEN_H, LEN_L and all data bytes).
//
// Ports:
//   sys_clk_i    single clock
//   sys_rst_n_i  asynchronous active-low reset
//   bus          j1_boot_ctrl_if.slave: rx byte stream, RAM write port, response
//   boot_req_i   reload request, honoured only while running
//   cpu_rst_o    active-high core reset, low only in RUN
//   busy_o       high whenever not in RUN
//   err_o        sticky error, set by 'E'/'T', cleared by 'K'
module j1_boot_ctrl #(
  parameter int DEPTH       = 8192,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_n_i,
  j1_boot_ctrl_if.slave bus,
  input  logic          boot_req_i,
  output logic          cpu_rst_o,
  output logic          busy_o,
  output logic          err_o
);

  // Timer only needs to reach TIMEOUT_CYC-1 before the expiry decision.
  localparam int          TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [31:0] DEPTH_U   = DEPTH;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [7:0]  RESP_K    = 8'h4B;
  localparam logic [7:0]  RESP_E    = 8'h45;
  localparam logic [7:0]  RESP_T    = 8'h54;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN_H,
    ST_LEN_L,
    ST_DATA_H,
    ST_DATA_L,
`ifdef J1_BOOT_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_RESP,
    ST_RUN
  } state_t;

  state_t        state, state_n;
  logic [7:0]    len_hi;
  logic [15:0]   len;
  logic [7:0]    hi_byte;
  logic [12:0]   word_idx;
  logic [TW-1:0] timer;
  logic          in_frame;
  logic          timeout_hit;
  logic          last_word;
  logic [15:0]   len_rx;
  logic          resp_fire;
  logic [7:0]    resp_code;
`ifdef J1_BOOT_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  assign len_rx    = {len_hi, bus.rx_data_i};
  assign last_word = ({3'd0, word_idx} == (len - 16'd1));

  assign in_frame = (state == ST_LEN_H) || (state == ST_LEN_L) ||
                    (state == ST_DATA_H) || (state == ST_DATA_L)
`ifdef J1_BOOT_CHECKSUM_EN
                    || (state == ST_CSUM)
`endif
                    ;

  // A byte arriving on the expiry cycle wins, hence the !rx_valid_i term.
  assign timeout_hit = in_frame && !bus.rx_valid_i && (timer == TW'(TIMEOUT_CYC - 1));

  assign cpu_rst_o      = (state != ST_RUN);
  assign busy_o         = (state != ST_RUN);
  assign bus.tx_valid_o = (state == ST_RESP);

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) state <= ST_SYNC;
    else              state <= state_n;
  end

  always_comb begin
    state_n   = state;
    resp_fire = 1'b0;
    resp_code = RESP_K;
    case (state)
      ST_SYNC:   if (bus.rx_valid_i && bus.rx_data_i == SYNC_BYTE) state_n = ST_LEN_H;
      ST_LEN_H:  if (bus.rx_valid_i) state_n = ST_LEN_L;
      ST_LEN_L:
        if (bus.rx_valid_i) begin
          if (len_rx == 16'd0 || {16'd0, len_rx} > DEPTH_U) begin
            state_n   = ST_RESP;
            resp_fire = 1'b1;
            resp_code = RESP_E;
          end else begin
            state_n = ST_DATA_H;
          end
        end
      ST_DATA_H: if (bus.rx_valid_i) state_n = ST_DATA_L;
      ST_DATA_L:
        if (bus.rx_valid_i) begin
          if (last_word) begin
`ifdef J1_BOOT_CHECKSUM_EN
            state_n   = ST_CSUM;
`else
            state_n   = ST_RESP;
            resp_fire = 1'b1;
            resp_code = RESP_K;
`endif
          end else begin
            state_n = ST_DATA_H;
          end
        end
`ifdef J1_BOOT_CHECKSUM_EN
      ST_CSUM:
        if (bus.rx_valid_i) begin
          state_n   = ST_RESP;
          resp_fire = 1'b1;
          resp_code = (bus.rx_data_i == csum) ? RESP_K : RESP_E;
        end
`endif
      ST_RESP:   if (bus.tx_ready_i) state_n = (bus.tx_data_o == RESP_K) ? ST_RUN : ST_SYNC;
      ST_RUN:    if (boot_req_i) state_n = ST_SYNC;
      default:   state_n = ST_SYNC;
    endcase
    if (timeout_hit) begin
      state_n   = ST_RESP;
      resp_fire = 1'b1;
      resp_code = RESP_T;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      timer          <= '0;
      len_hi         <= 8'd0;
      len            <= 16'd0;
      hi_byte        <= 8'd0;
      word_idx       <= 13'd0;
      bus.ram_we_o   <= 1'b0;
      bus.ram_addr_o <= 13'd0;
      bus.ram_data_o <= 16'd0;
      bus.tx_data_o  <= 8'd0;
      err_o          <= 1'b0;
    end else begin
      bus.ram_we_o <= 1'b0;

      if (!in_frame || bus.rx_valid_i || timeout_hit) timer <= '0;
      else                                            timer <= timer + 1'b1;

      if (bus.rx_valid_i) begin
        case (state)
          ST_LEN_H: len_hi <= bus.rx_data_i;
          ST_LEN_L: begin
            len      <= len_rx;
            word_idx <= 13'd0;
          end
          ST_DATA_H: hi_byte <= bus.rx_data_i;
          ST_DATA_L: begin
            bus.ram_we_o   <= 1'b1;
            bus.ram_addr_o <= word_idx;
            bus.ram_data_o <= {hi_byte, bus.rx_data_i};
            word_idx       <= word_idx + 13'd1;
          end
          default: ;
        endcase
      end

      if (resp_fire) begin
        bus.tx_data_o <= resp_code;
        err_o         <= (resp_code != RESP_K);
      end
    end
  end

`ifdef J1_BOOT_CHECKSUM_EN
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      csum <= 8'd0;
    end else if (state == ST_SYNC) begin
      csum <= 8'd0;
    end else if (bus.rx_valid_i && (state == ST_LEN_H || state == ST_LEN_L ||
                                    state == ST_DATA_H || state == ST_DATA_L)) begin
      csum <= csum ^ bus.rx_data_i;
    end
  end
`endif

endmodule

// File: tb/tb_j1_boot_ctrl.sv
// tb/tb_j1_boot_ctrl.sv - table-driven self-checking bench for j1_boot_ctrl
module tb_j1_boot_ctrl;

  logic sys_clk_i = 1'b0;
  logic sys_rst_n_i;
  logic boot_req_i;
  logic cpu_rst_o;
  logic busy_o;
  logic err_o;

  j1_boot_ctrl_if bus ();

  j1_boot_ctrl #(
    .DEPTH       (8192),
    .TIMEOUT_CYC (100)
  ) dut (
    .sys_clk_i   (sys_clk_i),
    .sys_rst_n_i (sys_rst_n_i),
    .bus         (bus),
    .boot_req_i  (boot_req_i),
    .cpu_rst_o   (cpu_rst_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  typedef struct {
    logic        rxv;
    logic [7:0]  rxd;
    logic        boot;
    logic        rdy;
    logic        we;
    logic [12:0] addr;
    logic [15:0] data;
    logic        txv;
    logic [7:0]  txd;
    logic        cpu;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   we_cnt = 0;
  int   wc0;
  logic ge;

  always @(negedge sys_clk_i) if (bus.ram_we_o === 1'b1) we_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (n_vec=%0d)", n_vec);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic rxv, input logic [7:0] rxd, input logic boot,
                              input logic rdy, input logic we, input logic [12:0] addr,
                              input logic [15:0] data, input logic txv, input logic [7:0] txd,
                              input logic cpu, input logic err);
    vec_t v;
    v.rxv = rxv; v.rxd = rxd; v.boot = boot; v.rdy = rdy; v.we = we; v.addr = addr;
    v.data = data; v.txv = txv; v.txd = txd; v.cpu = cpu; v.err = err;
    tbl.push_back(v);
  endfunction

  // Byte that produces no visible output change.
  function automatic void addb(input logic [7:0] d, input logic err);
    add(1'b1, d, 1'b0, 1'b0, 1'b0, 13'd0, 16'd0, 1'b0, 8'd0, 1'b1, err);
  endfunction

  task automatic step(input logic rxv, input logic [7:0] d, input logic rdy);
    bus.rx_valid_i = rxv;
    bus.rx_data_i  = d;
    bus.tx_ready_i = rdy;
    boot_req_i     = 1'b0;
    @(posedge sys_clk_i);
    @(negedge sys_clk_i);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    sys_rst_n_i    = 1'b0;
    boot_req_i     = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'd0;
    bus.tx_ready_i = 1'b0;
    repeat (3) @(negedge sys_clk_i);

    chk("rst.cpu_rst", cpu_rst_o, 1);
    chk("rst.busy", busy_o, 1);
    chk("rst.we", bus.ram_we_o, 0);
    chk("rst.txv", bus.tx_valid_o, 0);
    chk("rst.err", err_o, 0);
    chk("rst.addr", bus.ram_addr_o, 0);
    chk("rst.data", bus.ram_data_o, 0);
    chk("rst.txd", bus.tx_data_o, 0);
    sys_rst_n_i = 1'b1;

`ifdef J1_BOOT_CHECKSUM_EN
    ge = 1'b1;
`else
    ge = 1'b0;
`endif

    // Good two-word frame, handshake into RUN, then reload request.
    addb(8'hA5, 0); addb(8'h00, 0); addb(8'h02, 0); addb(8'h12, 0);
    add(1, 8'h34, 0, 0, 1, 13'd0, 16'h1234, 0, 8'h00, 1, 0);
    addb(8'hAB, 0);
`ifdef J1_BOOT_CHECKSUM_EN
    add(1, 8'hCD, 0, 0, 1, 13'd1, 16'hABCD, 0, 8'h00, 1, 0);
    add(1, 8'h42, 0, 0, 0, 13'd0, 16'd0, 1, 8'h4B, 1, 0);
`else
    add(1, 8'hCD, 0, 0, 1, 13'd1, 16'hABCD, 1, 8'h4B, 1, 0);
`endif
    add(0, 8'h00, 1, 0, 0, 13'd0, 16'd0, 1, 8'h4B, 1, 0);
    add(0, 8'h00, 0, 0, 0, 13'd0, 16'd0, 1, 8'h4B, 1, 0);
    add(0, 8'h00, 0, 1, 0, 13'd0, 16'd0, 0, 8'h00, 0, 0);
    add(1, 8'hA5, 0, 1, 0, 13'd0, 16'd0, 0, 8'h00, 0, 0);
    add(0, 8'h00, 1, 0, 0, 13'd0, 16'd0, 0, 8'h00, 1, 0);
`ifdef J1_BOOT_CHECKSUM_EN
    // Same frame with a bad checksum: writes stay, response 'E', back to SYNC.
    addb(8'hA5, 0); addb(8'h00, 0); addb(8'h02, 0); addb(8'h12, 0);
    add(1, 8'h34, 0, 0, 1, 13'd0, 16'h1234, 0, 8'h00, 1, 0);
    addb(8'hAB, 0);
    add(1, 8'hCD, 0, 0, 1, 13'd1, 16'hABCD, 0, 8'h00, 1, 0);
    add(1, 8'h43, 0, 0, 0, 13'd0, 16'd0, 1, 8'h45, 1, 1);
    add(0, 8'h00, 0, 1, 0, 13'd0, 16'd0, 0, 8'h00, 1, 1);
`endif
    // boot_req ignored in SYNC, then garbage before sync byte.
    add(0, 8'h00, 1, 0, 0, 13'd0, 16'd0, 0, 8'h00, 1, ge);
    addb(8'h00, ge); addb(8'hFF, ge); addb(8'h5A, ge);
    addb(8'hA5, ge); addb(8'h00, ge); addb(8'h01, ge); addb(8'h00, ge);
`ifdef J1_BOOT_CHECKSUM_EN
    add(1, 8'h07, 0, 0, 1, 13'd0, 16'h0007, 0, 8'h00, 1, ge);
    add(1, 8'h06, 0, 0, 0, 13'd0, 16'd0, 1, 8'h4B, 1, 0);
`else
    add(1, 8'h07, 0, 0, 1, 13'd0, 16'h0007, 1, 8'h4B, 1, 0);
`endif
    add(0, 8'h00, 0, 1, 0, 13'd0, 16'd0, 0, 8'h00, 0, 0);
    add(0, 8'h00, 1, 0, 0, 13'd0, 16'd0, 0, 8'h00, 1, 0);
    // LEN = 0 and LEN = DEPTH+1 are rejected.
    addb(8'hA5, 0); addb(8'h00, 0);
    add(1, 8'h00, 0, 0, 0, 13'd0, 16'd0, 1, 8'h45, 1, 1);
    add(0, 8'h00, 0, 1, 0, 13'd0, 16'd0, 0, 8'h00, 1, 1);
    addb(8'hA5, 1); addb(8'h20, 1);
    add(1, 8'h01, 0, 0, 0, 13'd0, 16'd0, 1, 8'h45, 1, 1);
    add(0, 8'h00, 0, 1, 0, 13'd0, 16'd0, 0, 8'h00, 1, 1);

    foreach (tbl[i]) begin
      bus.rx_valid_i = tbl[i].rxv;
      bus.rx_data_i  = tbl[i].rxd;
      boot_req_i     = tbl[i].boot;
      bus.tx_ready_i = tbl[i].rdy;
      @(posedge sys_clk_i);
      @(negedge sys_clk_i);
      chk($sformatf("v%0d.we", i), bus.ram_we_o, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("v%0d.addr", i), bus.ram_addr_o, tbl[i].addr);
        chk($sformatf("v%0d.data", i), bus.ram_data_o, tbl[i].data);
      end
      chk($sformatf("v%0d.txv", i), bus.tx_valid_o, tbl[i].txv);
      if (tbl[i].txv) chk($sformatf("v%0d.txd", i), bus.tx_data_o, tbl[i].txd);
      chk($sformatf("v%0d.cpu_rst", i), cpu_rst_o, tbl[i].cpu);
      chk($sformatf("v%0d.busy", i), busy_o, tbl[i].cpu);
      chk($sformatf("v%0d.err", i), err_o, tbl[i].err);
    end
    boot_req_i = 1'b0;
`ifdef J1_BOOT_CHECKSUM_EN
    chk("table.we_count", we_cnt, 5);
`else
    chk("table.we_count", we_cnt, 3);
`endif

    // Timeout in DATA_L after 100 idle cycles, response held while not ready.
    wc0 = we_cnt;
    step(1, 8'hA5, 0); step(1, 8'h00, 0); step(1, 8'h02, 0); step(1, 8'h11, 0);
    idle(99);
    chk("to.txv_before", bus.tx_valid_o, 0);
    step(0, 8'h00, 0);
    chk("to.txv", bus.tx_valid_o, 1);
    chk("to.txd", bus.tx_data_o, 8'h54);
    chk("to.err", err_o, 1);
    for (int k = 0; k < 5; k++) begin
      step(0, 8'h00, 0);
      chk($sformatf("to.hold%0d.txv", k), bus.tx_valid_o, 1);
      chk($sformatf("to.hold%0d.txd", k), bus.tx_data_o, 8'h54);
    end
    step(0, 8'h00, 1);
    chk("to.after_txv", bus.tx_valid_o, 0);
    chk("to.after_cpu", cpu_rst_o, 1);
    chk("to.we_count", we_cnt, wc0);

    // Byte on the expiry cycle restarts the timer.
    step(1, 8'hA5, 0);
    idle(99);
    step(1, 8'h00, 0);
    chk("tie.txv", bus.tx_valid_o, 0);
    idle(99);
    chk("tie.txv_before", bus.tx_valid_o, 0);
    step(0, 8'h00, 0);
    chk("tie.txv", bus.tx_valid_o, 1);
    chk("tie.txd", bus.tx_data_o, 8'h54);
    step(0, 8'h00, 1);
    chk("tie.after_txv", bus.tx_valid_o, 0);

    // Reset asserted while waiting for word 1's high byte.
    wc0 = we_cnt;
    step(1, 8'hA5, 0); step(1, 8'h00, 0); step(1, 8'h02, 0); step(1, 8'h12, 0);
    step(1, 8'h34, 0);
    chk("mr.we", bus.ram_we_o, 1);
    chk("mr.data", bus.ram_data_o, 16'h1234);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 8'hAB;
    #2 sys_rst_n_i = 1'b0;
    #1;
    chk("mr.cpu_rst", cpu_rst_o, 1);
    chk("mr.busy", busy_o, 1);
    chk("mr.err", err_o, 0);
    chk("mr.we_now", bus.ram_we_o, 0);
    chk("mr.addr", bus.ram_addr_o, 0);
    chk("mr.data0", bus.ram_data_o, 0);
    @(negedge sys_clk_i);
    sys_rst_n_i = 1'b1;
    step(1, 8'hAB, 0); step(1, 8'hCD, 0); idle(2);
    chk("mr.we_count", we_cnt, wc0 + 1);
    chk("mr.txv", bus.tx_valid_o, 0);
    chk("mr.cpu_after", cpu_rst_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
